// File: rtl/user_defined_timeout_backoff_pkg.sv
// rtl/user_defined_timeout_backoff_pkg.sv - shared widths, types and helpers for the timeout backoff block
// Contents: clogb2 helper, datapath widths, retransmit-mode encodings, stage payload structs.
package user_defined_timeout_backoff_pkg;

  function automatic int clogb2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int NUM_FLOWS   = 1024;
  localparam int FLOW_ID_W   = clogb2(NUM_FLOWS);
  localparam int SEQ_W       = 32;
  localparam int WIN_W       = 9;
  localparam int TIMER_W     = 32;
  localparam int CTX_W       = 64;
  localparam int BACKOFF_MAX = 6;
  localparam int CNT_W       = clogb2(BACKOFF_MAX + 1);

  typedef enum logic {
    RTX_GO_BACK_N = 1'b0,
    RTX_HEAD_ONLY = 1'b1
  } rtx_mode_e;

  typedef struct packed {
    logic [FLOW_ID_W-1:0] flow;
    logic                 expired;
    logic [SEQ_W-1:0]     wnd_start;
    logic [SEQ_W-1:0]     next_new;
    logic [WIN_W-1:0]     wnd;
    logic [TIMER_W-1:0]   timer;
    logic [CTX_W-1:0]     ctx;
  } event_t;

  typedef struct packed {
    logic [FLOW_ID_W-1:0] flow;
    logic                 mark;
    logic [SEQ_W-1:0]     rtx_start;
    logic [SEQ_W-1:0]     rtx_end;
    logic [WIN_W-1:0]     wnd;
    logic [TIMER_W-1:0]   timer;
    logic [CTX_W-1:0]     ctx;
    logic [CNT_W-1:0]     cnt;
  } result_t;

endpackage

// File: rtl/user_defined_timeout_backoff_if.sv
// rtl/user_defined_timeout_backoff_if.sv - event/result handshake bundle for the timeout backoff block
// master: timer wheel + downstream side (drives events, out_ready, ack clears)
// slave : the backoff block (drives in_ready and all result fields)
interface user_defined_timeout_backoff_if;
  import user_defined_timeout_backoff_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [FLOW_ID_W-1:0] flow_id_in;
  logic                 timeout_expired;
  logic [SEQ_W-1:0]     wnd_start_in;
  logic [SEQ_W-1:0]     next_new_in;
  logic [WIN_W-1:0]     wnd_size_in;
  logic [TIMER_W-1:0]   rtx_timer_amnt_in;
  logic [CTX_W-1:0]     user_cntxt_in;
  logic                 ack_clr_valid;
  logic [FLOW_ID_W-1:0] ack_clr_flow_id;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLOW_ID_W-1:0] flow_id_out;
  logic                 mark_rtx;
  logic [SEQ_W-1:0]     rtx_start;
  logic [SEQ_W-1:0]     rtx_end;
  logic [WIN_W-1:0]     wnd_size_out;
  logic [TIMER_W-1:0]   rtx_timer_amnt_out;
  logic [CTX_W-1:0]     user_cntxt_out;
  logic [CNT_W-1:0]     backoff_cnt_out;

  modport master (
    output in_valid, flow_id_in, timeout_expired, wnd_start_in, next_new_in, wnd_size_in,
           rtx_timer_amnt_in, user_cntxt_in, ack_clr_valid, ack_clr_flow_id, out_ready,
    input  in_ready, out_valid, flow_id_out, mark_rtx, rtx_start, rtx_end, wnd_size_out,
           rtx_timer_amnt_out, user_cntxt_out, backoff_cnt_out
  );

  modport slave (
    input  in_valid, flow_id_in, timeout_expired, wnd_start_in, next_new_in, wnd_size_in,
           rtx_timer_amnt_in, user_cntxt_in, ack_clr_valid, ack_clr_flow_id, out_ready,
    output in_ready, out_valid, flow_id_out, mark_rtx, rtx_start, rtx_end, wnd_size_out,
           rtx_timer_amnt_out, user_cntxt_out, backoff_cnt_out
  );
endinterface

// File: rtl/user_defined_timeout_backoff_table.sv
// rtl/user_defined_timeout_backoff_table.sv - per-flow backoff count register array
// Ports: clk, rst_n; rd_flow_i/rd_cnt_o async read; wr_en_i/wr_flow_i/wr_cnt_i write;
//        clr_en_i/clr_flow_i clear to zero (a same-cycle write to the same entry wins).
module timeout_backoff_table #(
  parameter int NUM_FLOWS = 1024,
  parameter int ID_W      = 10,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ID_W-1:0]  rd_flow_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [ID_W-1:0]  wr_flow_i,
  input  logic [CNT_W-1:0] wr_cnt_i,
  input  logic             clr_en_i,
  input  logic [ID_W-1:0]  clr_flow_i
);

  logic [CNT_W-1:0] mem_q [NUM_FLOWS];

  assign rd_cnt_o = mem_q[rd_flow_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FLOWS; i++) mem_q[i] <= '0;
    end else begin
      if (clr_en_i) mem_q[clr_flow_i] <= '0;
      // Later assignment takes priority, so the write overrides a clear of the same entry.
      if (wr_en_i) mem_q[wr_flow_i] <= wr_cnt_i;
    end
  end

endmodule

// File: rtl/user_defined_timeout_backoff.sv
// rtl/user_defined_timeout_backoff.sv - two-stage timeout policy: rtx range, window halving, RTO backoff
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the upstream event
//        handshake, the ack-clear request and the downstream result handshake.
module user_defined_timeout_backoff
  import user_defined_timeout_backoff_pkg::*;
#(
  parameter rtx_mode_e          RTX_MODE  = RTX_GO_BACK_N,
  parameter logic [TIMER_W-1:0] TIMER_MAX = '1,
  parameter logic [WIN_W-1:0]   MIN_WND   = 1
) (
  input logic clk,
  input logic rst_n,
  user_defined_timeout_backoff_if.slave bus
);

  event_t           s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  result_t          s2_q, s2_d;
  logic             s2_valid_q, s2_valid_d;

  result_t          res;
  logic [CNT_W-1:0] rd_cnt;
  logic             s2_ready, s1_adv, accept, wr_en;
  logic [TIMER_W:0] timer_x2;
  logic [WIN_W-1:0] half_wnd;

  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid_q && s2_ready;
  assign bus.in_ready = !s1_valid_q || s2_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // Only expiries change the count; pass-through events leave the table alone.
  assign wr_en        = s1_adv && s1_q.expired;

  timeout_backoff_table #(
    .NUM_FLOWS (NUM_FLOWS),
    .ID_W      (FLOW_ID_W),
    .CNT_W     (CNT_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_flow_i  (bus.flow_id_in),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (wr_en),
    .wr_flow_i  (s1_q.flow),
    .wr_cnt_i   (res.cnt),
    .clr_en_i   (bus.ack_clr_valid),
    .clr_flow_i (bus.ack_clr_flow_id)
  );

  // Policy computed from the S1 registers; registered into S2 on advance.
  always_comb begin
    timer_x2  = {1'b0, s1_q.timer} << 1;
    half_wnd  = s1_q.wnd >> 1;
    res       = '0;
    res.flow  = s1_q.flow;
    res.ctx   = s1_q.ctx;
    res.wnd   = s1_q.wnd;
    res.timer = s1_q.timer;
    res.cnt   = s1_cnt_q;
    if (s1_q.expired) begin
      if (s1_q.next_new != s1_q.wnd_start) begin
        res.mark      = 1'b1;
        res.rtx_start = s1_q.wnd_start;
        res.rtx_end   = (RTX_MODE == RTX_HEAD_ONLY) ? s1_q.wnd_start + SEQ_W'(1) : s1_q.next_new;
      end
      res.wnd = (half_wnd < MIN_WND) ? MIN_WND : half_wnd;
      if (s1_cnt_q < CNT_W'(BACKOFF_MAX)) begin
        res.timer = (timer_x2 > {1'b0, TIMER_MAX}) ? TIMER_MAX : timer_x2[TIMER_W-1:0];
        res.cnt   = s1_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s1_cnt_d   = s1_cnt_q;
    if (accept) begin
      s1_valid_d     = 1'b1;
      s1_d.flow      = bus.flow_id_in;
      s1_d.expired   = bus.timeout_expired;
      s1_d.wnd_start = bus.wnd_start_in;
      s1_d.next_new  = bus.next_new_in;
      s1_d.wnd       = bus.wnd_size_in;
      s1_d.timer     = bus.rtx_timer_amnt_in;
      s1_d.ctx       = bus.user_cntxt_in;
      // Capture the value the table will hold after this edge: S2 write, then clear, then stored.
      if (wr_en && s1_q.flow == bus.flow_id_in)
        s1_cnt_d = res.cnt;
      else if (bus.ack_clr_valid && bus.ack_clr_flow_id == bus.flow_id_in)
        s1_cnt_d = '0;
      else
        s1_cnt_d = rd_cnt;
    end else begin
      if (s1_adv) s1_valid_d = 1'b0;
      // Keep a held S1 count coherent with an ack clear landing while it waits.
      if (bus.ack_clr_valid && bus.ack_clr_flow_id == s1_q.flow) s1_cnt_d = '0;
    end
  end

  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s1_cnt_q   <= s1_cnt_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign bus.out_valid          = s2_valid_q;
  assign bus.flow_id_out        = s2_q.flow;
  assign bus.mark_rtx           = s2_q.mark;
  assign bus.rtx_start          = s2_q.rtx_start;
  assign bus.rtx_end            = s2_q.rtx_end;
  assign bus.wnd_size_out       = s2_q.wnd;
  assign bus.rtx_timer_amnt_out = s2_q.timer;
  assign bus.user_cntxt_out     = s2_q.ctx;
  assign bus.backoff_cnt_out    = s2_q.cnt;

endmodule

// File: tb/tb_user_defined_timeout_backoff.sv
// tb/tb_user_defined_timeout_backoff.sv - directed self-checking bench for user_defined_timeout_backoff
module tb_user_defined_timeout_backoff;
  import user_defined_timeout_backoff_pkg::*;

  typedef struct packed {
    logic [9:0]  flow;
    logic        ex;
    logic [31:0] ws;
    logic [31:0] nn;
    logic [8:0]  wnd;
    logic [31:0] tmr;
    logic        e_mark;
    logic [31:0] e_rs;
    logic [31:0] e_re;
    logic [8:0]  e_wnd;
    logic [31:0] e_tmr;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct packed {
    logic [9:0]  flow;
    logic        mark;
    logic [31:0] rs;
    logic [31:0] re;
    logic [8:0]  wnd;
    logic [31:0] tmr;
    logic [63:0] ctx;
    logic [2:0]  cnt;
    logic [31:0] cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = 0;
  res_t q[$];
  vec_t vecs[6];

  user_defined_timeout_backoff_if if0 ();
  user_defined_timeout_backoff_if if1 ();

  user_defined_timeout_backoff #(.RTX_MODE(RTX_GO_BACK_N)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  user_defined_timeout_backoff #(.RTX_MODE(RTX_HEAD_ONLY)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t snap0();
    res_t r;
    r.flow = if0.flow_id_out; r.mark = if0.mark_rtx; r.rs = if0.rtx_start; r.re = if0.rtx_end;
    r.wnd = if0.wnd_size_out; r.tmr = if0.rtx_timer_amnt_out; r.ctx = if0.user_cntxt_out;
    r.cnt = if0.backoff_cnt_out; r.cyc = cyc;
    return r;
  endfunction

  function automatic res_t snap1();
    res_t r;
    r.flow = if1.flow_id_out; r.mark = if1.mark_rtx; r.rs = if1.rtx_start; r.re = if1.rtx_end;
    r.wnd = if1.wnd_size_out; r.tmr = if1.rtx_timer_amnt_out; r.ctx = if1.user_cntxt_out;
    r.cnt = if1.backoff_cnt_out; r.cyc = cyc;
    return r;
  endfunction

  always @(negedge clk) if (rst_n && if0.out_valid && if0.out_ready) q.push_back(snap0());

  function automatic vec_t mk(input logic [9:0] f, input logic ex, input logic [31:0] ws, input logic [31:0] nn,
                              input logic [8:0] w, input logic [31:0] t, input logic em, input logic [31:0] ers,
                              input logic [31:0] ere, input logic [8:0] ew, input logic [31:0] et, input logic [2:0] ec);
    vec_t v;
    v.flow = f; v.ex = ex; v.ws = ws; v.nn = nn; v.wnd = w; v.tmr = t;
    v.e_mark = em; v.e_rs = ers; v.e_re = ere; v.e_wnd = ew; v.e_tmr = et; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic [63:0] ctx_of(input vec_t v);
    return {22'h2C0DE, v.flow, v.tmr ^ v.ws};
  endfunction

  function automatic res_t pop();
    res_t r = '0;
    if (q.size() > 0) r = q.pop_front();
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input vec_t e, input res_t r);
    chk({tag, " flow"}, 64'(r.flow), 64'(e.flow));
    chk({tag, " mark_rtx"}, 64'(r.mark), 64'(e.e_mark));
    chk({tag, " rtx_start"}, 64'(r.rs), 64'(e.e_rs));
    chk({tag, " rtx_end"}, 64'(r.re), 64'(e.e_re));
    chk({tag, " wnd"}, 64'(r.wnd), 64'(e.e_wnd));
    chk({tag, " timer"}, 64'(r.tmr), 64'(e.e_tmr));
    chk({tag, " cnt"}, 64'(r.cnt), 64'(e.e_cnt));
    chk({tag, " ctx"}, r.ctx, ctx_of(e));
  endtask

  // Presents an event from posedge+1 and returns at posedge+1 after the accepting edge.
  task automatic drive(input vec_t v);
    int k = 0;
    if0.flow_id_in = v.flow; if0.timeout_expired = v.ex; if0.wnd_start_in = v.ws;
    if0.next_new_in = v.nn; if0.wnd_size_in = v.wnd; if0.rtx_timer_amnt_in = v.tmr;
    if0.user_cntxt_in = ctx_of(v); if0.in_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!if0.in_ready && k < 60);
    if (!if0.in_ready) begin
      checks++; errors++;
      $display("FAIL accept flow %0d: in_ready 0 after %0d cycles, required 1", v.flow, k);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (q.size() < n && k < 60) begin @(negedge clk); k++; end
    if (q.size() < n) begin
      checks++; errors++;
      $display("FAIL result wait: got %0d results, required %0d", q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    res_t r;
    res_t rr[7];
    logic [31:0] acc;
    int k;

    if0.in_valid = 0; if0.flow_id_in = 0; if0.timeout_expired = 0; if0.wnd_start_in = 0;
    if0.next_new_in = 0; if0.wnd_size_in = 0; if0.rtx_timer_amnt_in = 0; if0.user_cntxt_in = 0;
    if0.ack_clr_valid = 0; if0.ack_clr_flow_id = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.flow_id_in = 0; if1.timeout_expired = 0; if1.wnd_start_in = 0;
    if1.next_new_in = 0; if1.wnd_size_in = 0; if1.rtx_timer_amnt_in = 0; if1.user_cntxt_in = 0;
    if1.ack_clr_valid = 0; if1.ack_clr_flow_id = 0; if1.out_ready = 1;

    vecs[0] = mk(3, 1, 100, 140, 32, 1000,         1, 100, 140, 16, 2000, 1);
    vecs[1] = mk(7, 1, 200, 200, 1, 500,           0, 0, 0, 1, 1000, 1);
    vecs[2] = mk(7, 0, 10, 20, 8, 777,             0, 0, 0, 8, 777, 1);
    vecs[3] = mk(3, 1, 100, 150, 16, 2000,         1, 100, 150, 8, 4000, 2);
    vecs[4] = mk(9, 1, 0, 5, 0, 32'h9000_0000,     1, 0, 5, 1, 32'hFFFF_FFFF, 1);
    vecs[5] = mk(9, 1, 5, 4, 3, 32'h10,            1, 5, 4, 1, 32'h20, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(if0.out_valid), 0);
    chk("reset mark_rtx", 64'(if0.mark_rtx), 0);
    chk("reset timer_out", 64'(if0.rtx_timer_amnt_out), 0);
    chk("reset cnt_out", 64'(if0.backoff_cnt_out), 0);
    rst_n = 1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(if0.in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      acc = cyc;
      if0.in_valid = 0;
      wait_q(1);
      r = pop();
      check_res($sformatf("vec%0d", i), vecs[i], r);
      chk($sformatf("vec%0d latency", i), 64'(r.cyc), 64'(acc + 1));
    end

    for (int i = 0; i < 7; i++) drive(mk(5, 1, 10, 20, 8, 1000, 0, 0, 0, 0, 0, 0));
    if0.in_valid = 0;
    wait_q(7);
    for (int i = 0; i < 7; i++) rr[i] = pop();
    for (int i = 0; i < 7; i++) begin
      v = mk(5, 1, 10, 20, 8, 1000, 1, 10, 20, 4, (i < 6) ? 32'd2000 : 32'd1000, (i < 6) ? 3'(i + 1) : 3'd6);
      check_res($sformatf("b2b%0d", i), v, rr[i]);
      chk($sformatf("b2b%0d cycle", i), 64'(rr[i].cyc), 64'(rr[0].cyc + i));
    end

    if1.flow_id_in = 2; if1.timeout_expired = 1; if1.wnd_start_in = 32'hFFFF_FFFF;
    if1.next_new_in = 10; if1.wnd_size_in = 4; if1.rtx_timer_amnt_in = 32'h9000_0000;
    if1.user_cntxt_in = 64'hFEED_F00D_0000_0002; if1.in_valid = 1;
    @(negedge clk);
    chk("mode1 in_ready", 64'(if1.in_ready), 1);
    @(posedge clk); #1;
    if1.in_valid = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!if1.out_valid && k < 20);
    r = snap1();
    chk("mode1 out_valid", 64'(if1.out_valid), 1);
    chk("mode1 mark_rtx", 64'(r.mark), 1);
    chk("mode1 rtx_start", 64'(r.rs), 64'hFFFF_FFFF);
    chk("mode1 rtx_end wrap", 64'(r.re), 0);
    chk("mode1 wnd", 64'(r.wnd), 2);
    chk("mode1 timer sat", 64'(r.tmr), 64'hFFFF_FFFF);
    chk("mode1 cnt", 64'(r.cnt), 1);
    chk("mode1 ctx", r.ctx, 64'hFEED_F00D_0000_0002);
    @(posedge clk); #1;

    if0.out_ready = 0;
    fork
      begin
        drive(mk(20, 0, 1, 2, 5, 11, 0, 0, 0, 0, 0, 0));
        drive(mk(21, 0, 1, 2, 6, 12, 0, 0, 0, 0, 0, 0));
        drive(mk(22, 0, 1, 2, 7, 13, 0, 0, 0, 0, 0, 0));
        if0.in_valid = 0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall in_ready", 64'(if0.in_ready), 0);
        for (int j = 0; j < 4; j++) begin
          if (j > 0) @(negedge clk);
          chk($sformatf("stall%0d out_valid", j), 64'(if0.out_valid), 1);
          chk($sformatf("stall%0d flow", j), 64'(if0.flow_id_out), 20);
          chk($sformatf("stall%0d wnd", j), 64'(if0.wnd_size_out), 5);
          chk($sformatf("stall%0d ctx", j), if0.user_cntxt_out, ctx_of(mk(20, 0, 1, 2, 5, 11, 0, 0, 0, 0, 0, 0)));
        end
        @(posedge clk); #1;
        if0.out_ready = 1;
      end
    join
    wait_q(3);
    for (int i = 0; i < 3; i++) begin
      r = pop();
      v = mk(10'(20 + i), 0, 1, 2, 9'(5 + i), 32'(11 + i), 0, 0, 0, 9'(5 + i), 32'(11 + i), 0);
      check_res($sformatf("stall order%0d", i), v, r);
    end

    drive(mk(3, 1, 0, 1, 2, 100, 0, 0, 0, 0, 0, 0));
    if0.in_valid = 0;
    if0.ack_clr_valid = 1; if0.ack_clr_flow_id = 3;
    @(posedge clk); #1;
    if0.ack_clr_valid = 0;
    wait_q(1);
    check_res("ackwr first", mk(3, 1, 0, 1, 2, 100, 1, 0, 1, 1, 200, 3), pop());
    drive(mk(3, 1, 0, 1, 2, 100, 0, 0, 0, 0, 0, 0));
    if0.in_valid = 0;
    wait_q(1);
    check_res("ackwr second", mk(3, 1, 0, 1, 2, 100, 1, 0, 1, 1, 200, 4), pop());

    if0.ack_clr_valid = 1; if0.ack_clr_flow_id = 5;
    @(posedge clk); #1;
    if0.ack_clr_valid = 0;
    drive(mk(5, 1, 10, 20, 8, 1000, 0, 0, 0, 0, 0, 0));
    if0.in_valid = 0;
    wait_q(1);
    check_res("ack idle", mk(5, 1, 10, 20, 8, 1000, 1, 10, 20, 4, 2000, 1), pop());

    drive(mk(11, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    drive(mk(11, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    chk("pre-reset out_valid", 64'(if0.out_valid), 1);
    rst_n = 0;
    if0.in_valid = 0;
    #1;
    chk("mid reset out_valid", 64'(if0.out_valid), 0);
    chk("mid reset flow_out", 64'(if0.flow_id_out), 0);
    chk("mid reset timer_out", 64'(if0.rtx_timer_amnt_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("dropped events", 64'(q.size()), 0);
    drive(mk(11, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    drive(mk(3, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    drive(mk(5, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    drive(mk(9, 1, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0));
    if0.in_valid = 0;
    wait_q(4);
    check_res("cleared f11", mk(11, 1, 1, 2, 4, 1, 1, 1, 2, 2, 2, 1), pop());
    check_res("cleared f3", mk(3, 1, 1, 2, 4, 1, 1, 1, 2, 2, 2, 1), pop());
    check_res("cleared f5", mk(5, 1, 1, 2, 4, 1, 1, 1, 2, 2, 2, 1), pop());
    check_res("cleared f9", mk(9, 1, 1, 2, 4, 1, 1, 1, 2, 2, 2, 1), pop());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
